ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Round-robin arbiter that shares one port of the team's 16-entry × 4-bit synchronous-address RAM between `NREQ` requesters. Each requester issues single-word reads or writes over a valid/ready handshake. The arbiter drives the RAM port and routes read data back to the issuing requester one cycle later. A lock input lets a requester hold the port for back-to-back accesses (read-modify-write), bounded by a counter so that no other requester starves.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters, 2..8.
- `AW`, default 4: RAM address width.
- `DW`, default 4: RAM data width.
- `MAX_LOCK`, default 4: maximum consecutive grants to one locked requester, ≥1.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  request accepted this cycle (one-hot or zero).
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_lock`  in  NREQ  keep grant after this access.
- `req_addr`  in  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- `req_wdata`  in  NREQ*DW  packed write data.
- `rsp_valid`  out  NREQ  read data valid for requester i (one-hot or zero).
- `rsp_rdata`  out  DW  read data, shared bus.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  AW  RAM address.
- `ram_wdata`  out  DW  RAM write data.
- `ram_rdata`  in  DW  RAM output, addressed by the address registered at the previous edge.

## Operation
- Grant selection is combinational each cycle:
  - If `lock_owner` is valid, `req_valid[lock_owner]` = 1 and `lock_cnt` < `MAX_LOCK`, the grant goes to `lock_owner`.
  - Otherwise the grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward modulo NREQ.
- `req_ready[g]` = 1 only for the granted requester, and only when its `req_valid` is set. An access happens on the cycle where valid and ready are both 1.
- On an access by g:
  - `ram_addr`/`ram_wdata` take g's fields; `ram_we` = `req_we[g]`.
  - With no access, `ram_we` = 0, and `ram_addr`/`ram_wdata` hold their last granted values (registered mux select) so that the RAM read address does not toggle.
- Round-robin pointer: after an unlocked access by g, `rr_ptr` ← (g+1) mod NREQ. A locked access leaves `rr_ptr` unchanged.
- Lock state:
  - An access with `req_lock[g]` = 1 sets `lock_owner` ← g and `lock_cnt` ← `lock_cnt`+1 (it is 1 after the first locked access).
  - An access with `req_lock[g]` = 0 clears the lock and `lock_cnt`.
  - Lock is released after `MAX_LOCK` consecutive grants. The next grant is chosen by round-robin starting from `lock_owner`+1, and `lock_cnt` resets.
  - Lock is also released if the owner drops `req_valid` for one cycle. That cycle arbitrates normally.
- Read response: a read access in cycle t sets the tracking register `rsp_pend` ← one-hot(g). In cycle t+1, `rsp_valid` = `rsp_pend` and `rsp_rdata` = `ram_rdata`. No backpressure on responses.
- Write-first: a read issued the cycle after a write to the same address returns the new data. This is the RAM's native behaviour; the arbiter adds no forwarding.

## Timing
- Reset values: `rr_ptr` = 0, `lock_owner` invalid, `lock_cnt` = 0, `rsp_pend` = 0.
- Reset output values: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `ram_we` = 0, `ram_addr` = 0, `ram_wdata` = 0.
- Accept-to-response latency for reads: 1 cycle. Throughput: one access per cycle overall.
- Worst-case wait for an unlocked requester with `req_valid` held: (NREQ−1)·`MAX_LOCK` cycles.
- `rst_n` deasserted mid-operation:
  - In-flight `rsp_pend` is dropped; no `rsp_valid` is issued for it.
  - `ram_we` is forced to 0 immediately (asynchronous).
- Requesters must hold their fields stable while `req_valid` = 1 and `req_ready` = 0.

## Structure
- Shared package `ram_arb_pkg`: lock-count width function `clog2(MAX_LOCK+1)` and the requester-index width `clog2(NREQ)`.
- One sub-module: `rr_pick`, a combinational round-robin priority selector with inputs (`req` vector, start pointer) and outputs (one-hot grant, index, any).

## Test plan
- Single reads: NREQ=2. Write addr 3 ← 0xA via requester 0, then read addr 3 via requester 1 → `rsp_valid` = 2'b10 one cycle after accept, `rsp_rdata` = 0xA.
- Contention: both requesters valid with unlocked reads for 4 cycles from reset → grants alternate 0,1,0,1 and `rr_ptr` ends at 0.
- Lock bound: MAX_LOCK=4. Requester 0 holds valid and lock, requester 1 valid → requester 0 gets 4 grants, then requester 1 gets 1, then requester 0 again.
- Read-after-write at the same address in consecutive cycles by different requesters (addr 5 ← 0x7, then read 5) → response 0x7.
- Lock drop: requester 0 locks, then deasserts `req_valid` for one cycle while requester 1 waits → requester 1 is granted that cycle and the lock is cleared.
- Reset mid-read: assert `rst_n` = 0 in the cycle after a read accept → `rsp_valid` stays 0, and all outputs are 0 while in reset.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared sizing helpers for the RAM port arbiter.
//   idx_w(n) : width of a requester index for n requesters (at least 1 bit)
//   cnt_w(m) : width of a lock counter that must hold values 0..m
package ram_arb_pkg;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req_i   : request vector
//   start_i : index searched first; search proceeds upward modulo N
//   gnt_o   : one-hot grant (zero when no request)
//   idx_o   : index of the granted request
//   any_o   : at least one request present
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    logic [IW-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = IW'((32'(start_i) + i) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        idx_o    = j;
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter sharing one synchronous-address RAM
// port between NREQ requesters, with a bounded lock for back-to-back access.
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_we/req_lock     : per-requester write enable and keep-grant request
//   req_addr/req_wdata  : packed per-requester address and write data
//   rsp_valid/rsp_rdata : read response, one cycle after a read is accepted
//   ram_we/ram_addr/ram_wdata/ram_rdata : RAM port
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 4,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ-1:0]    req_lock,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               ram_we,
  output logic [AW-1:0]      ram_addr,
  output logic [DW-1:0]      ram_wdata,
  input  logic [DW-1:0]      ram_rdata
);

  localparam int unsigned IW = idx_w(NREQ);
  localparam int unsigned LW = cnt_w(MAX_LOCK);

  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            lock_vld_q, lock_vld_d;
  logic [IW-1:0]   lock_owner_q, lock_owner_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NREQ-1:0] rsp_pend_q, rsp_pend_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            lock_expired, lock_hit, access;
  logic [IW-1:0]   start, g;
  logic [NREQ-1:0] pick_gnt, gnt_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            sel_we, sel_lock;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  function automatic logic [IW-1:0] inc_mod(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  always_comb begin
    lock_expired = lock_vld_q && (lock_cnt_q >= LW'(MAX_LOCK));
    lock_hit     = lock_vld_q && req_valid[lock_owner_q] && !lock_expired;
    // Once the lock budget is spent, fairness restarts just past the owner.
    start        = lock_expired ? inc_mod(lock_owner_q) : rr_ptr_q;
  end

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req_i   (req_valid),
    .start_i (start),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant, requester field mux and RAM port drive.
  always_comb begin
    g      = lock_hit ? lock_owner_q : pick_idx;
    // Gating with rst_n keeps every port output quiet while reset is held.
    access = rst_n && (lock_hit || (pick_any && (pick_gnt != '0)));
    gnt_oh = '0;
    if (access) gnt_oh[g] = 1'b1;

    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IW'(k) == g) begin
        sel_we    = req_we[k];
        sel_lock  = req_lock[k];
        sel_addr  = req_addr[k*AW +: AW];
        sel_wdata = req_wdata[k*DW +: DW];
      end
    end

    req_ready = gnt_oh;
    ram_we    = access && sel_we;
    // Idle cycles replay the last granted fields so the RAM address is stable.
    ram_addr  = access ? sel_addr  : addr_q;
    ram_wdata = access ? sel_wdata : wdata_q;
    rsp_valid = rsp_pend_q;
    rsp_rdata = (rsp_pend_q != '0) ? ram_rdata : '0;
  end

  // Next-state: round-robin pointer, lock tracking, response tracking.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    rsp_pend_d   = '0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    // Owner stepping away or budget exhausted ends the lock this cycle.
    if (lock_vld_q && (!req_valid[lock_owner_q] || lock_expired)) begin
      lock_vld_d = 1'b0;
      lock_cnt_d = '0;
    end

    if (access) begin
      addr_d  = sel_addr;
      wdata_d = sel_wdata;
      if (!sel_we) rsp_pend_d = gnt_oh;
      if (sel_lock) begin
        lock_vld_d   = 1'b1;
        lock_owner_d = g;
        lock_cnt_d   = lock_hit ? lock_cnt_q + LW'(1) : LW'(1);
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
        rr_ptr_d   = inc_mod(g);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      rsp_pend_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter (NREQ=2,
// MAX_LOCK=4) with a behavioural 16x4 synchronous-address RAM attached.
module tb_ram_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [7:0] req_addr, req_wdata;
  logic [3:0] rsp_rdata, ram_addr, ram_wdata, ram_rdata;
  logic       ram_we;

  ram_port_arbiter #(
    .NREQ     (2),
    .AW       (4),
    .DW       (4),
    .MAX_LOCK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM: write and address capture on the same edge, read of the captured address.
  logic [3:0] mem [16];
  logic [3:0] ram_a_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_a_q <= ram_addr;
  end
  assign ram_rdata = mem[ram_a_q];

  typedef struct {
    logic [1:0] who;
    logic [3:0] data;
  } exp_t;

  exp_t       sb [$];
  logic [3:0] shadow [16];
  int         n_cmp = 0;
  int         n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".ready"}, 32'(req_ready), 32'd0);
    check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check({tag, ".ram_we"}, 32'(ram_we), 32'd0);
    check({tag, ".ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'd0);
  endtask

  // One arbitration cycle: drive, check grant and RAM port mid-cycle,
  // then after the edge compare any response owed by the previous accept.
  task automatic do_cycle(input string tag, input logic [1:0] v, input logic [1:0] we,
                          input logic [1:0] lk, input logic [7:0] ad, input logic [7:0] wd,
                          input logic [1:0] exp_rdy, input bit no_rsp = 1'b0);
    logic       gi, rd;
    logic [3:0] a_g, w_g;
    exp_t       e;
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = ad;
    req_wdata = wd;
    #4;
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_rdy));
    rd = 1'b0;
    if (exp_rdy != 2'b00) begin
      gi  = exp_rdy[1];
      a_g = gi ? ad[7:4] : ad[3:0];
      w_g = gi ? wd[7:4] : wd[3:0];
      check({tag, ".ram_addr"}, 32'(ram_addr), 32'(a_g));
      check({tag, ".ram_we"}, 32'(ram_we), 32'(we[gi]));
      if (we[gi]) begin
        check({tag, ".ram_wdata"}, 32'(ram_wdata), 32'(w_g));
        shadow[a_g] = w_g;
      end else begin
        rd = 1'b1;
        if (!no_rsp) sb.push_back('{who: exp_rdy, data: shadow[a_g]});
      end
    end else begin
      check({tag, ".ram_we"}, 32'(ram_we), 32'd0);
    end
    @(posedge clk);
    #1;
    if (!no_rsp) begin
      if (rd) begin
        e = sb.pop_front();
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(e.who));
        check({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(e.data));
      end else begin
        check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;

    #12;
    check_idle("reset");
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_lock  = 2'b11;
    req_addr  = 8'hFF;
    req_wdata = 8'hFF;
    #2;
    check_idle("reset_busy");
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single write then read by the other requester
    do_cycle("wr3", 2'b01, 2'b01, 2'b00, 8'h03, 8'h0A, 2'b01);
    do_cycle("rd3", 2'b10, 2'b00, 2'b00, 8'h30, 8'h00, 2'b10);

    // read-after-write at the same address, consecutive cycles
    do_cycle("raw_wr", 2'b11, 2'b01, 2'b00, 8'h55, 8'h07, 2'b01);
    do_cycle("raw_rd", 2'b10, 2'b00, 2'b00, 8'h55, 8'h00, 2'b10);

    // unlocked contention alternates, pointer back at 0
    do_cycle("cont0", 2'b11, 2'b00, 2'b00, 8'h35, 8'h00, 2'b01);
    do_cycle("cont1", 2'b11, 2'b00, 2'b00, 8'h53, 8'h00, 2'b10);
    do_cycle("cont2", 2'b11, 2'b00, 2'b00, 8'h35, 8'h00, 2'b01);
    do_cycle("cont3", 2'b11, 2'b00, 2'b00, 8'h53, 8'h00, 2'b10);
    do_cycle("rr_end0", 2'b11, 2'b00, 2'b00, 8'h35, 8'h00, 2'b01);
    do_cycle("rr_end1", 2'b11, 2'b00, 2'b00, 8'h35, 8'h00, 2'b10);

    // lock bound: four locked grants, one for the waiter, then owner again
    do_cycle("lk0", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("lk1", 2'b11, 2'b00, 2'b01, 8'h53, 8'h00, 2'b01);
    do_cycle("lk2", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("lk3", 2'b11, 2'b00, 2'b01, 8'h53, 8'h00, 2'b01);
    do_cycle("lk4", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b10);
    do_cycle("lk5", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("idle0", 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00);

    // lock drop: owner releases valid for a cycle, waiter served, count restarts
    do_cycle("drop0", 2'b01, 2'b00, 2'b01, 8'h03, 8'h00, 2'b01);
    do_cycle("drop1", 2'b10, 2'b00, 2'b00, 8'h50, 8'h00, 2'b10);
    do_cycle("relk0", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("relk1", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("relk2", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("relk3", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b01);
    do_cycle("relk4", 2'b11, 2'b00, 2'b01, 8'h35, 8'h00, 2'b10);
    do_cycle("idle1", 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00);

    // reset in the cycle after a read accept drops the response
    do_cycle("rst_rd", 2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 2'b01, 1'b1);
    check("rst_pre.rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_we    = 2'b11;
    req_addr  = 8'hFF;
    req_wdata = 8'hFF;
    #1;
    check_idle("rst_mid");
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_drop.rsp_valid", 32'(rsp_valid), 32'd0);
    do_cycle("post_rd", 2'b01, 2'b00, 2'b00, 8'h03, 8'h00, 2'b01);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
